// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU op sequencer: FSM state encoding and result-flag bit positions.
// No logic here, so there is no latency and no backpressure.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int FLAG_Z   = 3;
  localparam int FLAG_O   = 2;
  localparam int FLAG_CA  = 1;
  localparam int FLAG_NEG = 0;

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not A, 6 shl A, 7 shr A, others pass A.
// Zero latency with no backpressure; Ca is carry-out (or no-borrow on sub, or the shifted-out bit on shifts).
module alu #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   sel,
  output logic [N-1:0] out,
  output logic         Z,
  output logic         O,
  output logic         Ca,
  output logic         Neg
);

  logic [N:0] wide;

  always_comb begin
    wide = '0;
    O    = 1'b0;
    case (sel)
      4'd0: begin
        wide = {1'b0, A} + {1'b0, B};
        O    = (A[N-1] == B[N-1]) && (wide[N-1] != A[N-1]);
      end
      4'd1: begin
        wide = {1'b0, A} + {1'b0, ~B} + (N+1)'(1);
        O    = (A[N-1] != B[N-1]) && (wide[N-1] != A[N-1]);
      end
      4'd2:    wide = {1'b0, A & B};
      4'd3:    wide = {1'b0, A | B};
      4'd4:    wide = {1'b0, A ^ B};
      4'd5:    wide = {1'b0, ~A};
      4'd6:    wide = {A, 1'b0};
      4'd7:    wide = {A[0], 1'b0, A[N-1:1]};
      default: wide = {1'b0, A};
    endcase
    out = wide[N-1:0];
    Ca  = wide[N];
    Z   = (wide[N-1:0] == '0);
    Neg = wide[N-1];
  end

endmodule

// File: rtl/alu_res_fifo.sv
// Result FIFO, DEPTH entries of W bits; head is read combinationally, and a write lands one cycle later.
// A push is refused when the FIFO is full unless a pop happens on the same edge; a pop on an empty FIFO is ignored.
module alu_res_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rp];

  // Storage is cleared too, so the head never shows a result from before reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= push_dat;
        wp      <= wp + AW'(1);
      end
      if (do_pop) rp <= rp + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation at a time (IDLE->EXEC->WRITE) into a result FIFO; the result is queued 2 edges after the handshake.
// Accepts a request only in IDLE; stalls in WRITE while the FIFO is full and nothing is popped.
import alu_seq_pkg::*;

module alu_op_sequencer #(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [N-1:0]           req_a,
  input  logic [N-1:0]           req_b,
  input  logic [3:0]             req_sel,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [N-1:0]           res_out,
  output logic [3:0]             res_flags,
  output logic [$clog2(DEPTH):0] res_count
);

  state_t       state;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [3:0]   op_sel;
  logic [N-1:0] alu_out;
  logic         alu_z;
  logic         alu_o;
  logic         alu_ca;
  logic         alu_neg;
  logic [3:0]   alu_flags;
  logic [N+3:0] cap;
  logic [N+3:0] head;
  logic         fifo_full;
  logic         push;
  logic         pop;

  alu #(.N(N)) u_alu (
    .A   (op_a),
    .B   (op_b),
    .sel (op_sel),
    .out (alu_out),
    .Z   (alu_z),
    .O   (alu_o),
    .Ca  (alu_ca),
    .Neg (alu_neg)
  );

  always_comb begin
    alu_flags           = '0;
    alu_flags[FLAG_Z]   = alu_z;
    alu_flags[FLAG_O]   = alu_o;
    alu_flags[FLAG_CA]  = alu_ca;
    alu_flags[FLAG_NEG] = alu_neg;
  end

  assign req_ready = (state == IDLE) && !rst;
  assign pop       = res_valid && res_ready;
  assign push      = (state == WRITE) && (!fifo_full || pop);

  alu_res_fifo #(.W(N + 4), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (cap),
    .pop      (pop),
    .head     (head),
    .count    (res_count),
    .full     (fifo_full)
  );

  assign res_valid = (res_count != '0);
  assign res_out   = head[N+3:4];
  assign res_flags = head[3:0];

  // The capture register holds its value across a WRITE stall, so nothing is lost while the FIFO is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      op_sel <= '0;
      cap    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_a   <= req_a;
            op_b   <= req_b;
            op_sel <= req_sel;
            state  <= EXEC;
          end
        end
        EXEC: begin
          cap   <= {alu_out, alu_flags};
          state <= WRITE;
        end
        WRITE: begin
          if (push) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
